// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline controller: per-stage stall/flush generation, enter-button
// start gating, single-step debug mode and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int N_STAGE = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic               mode_step,
    input  logic [N_STAGE-1:0] stall_req,
    input  logic [N_STAGE-1:0] flush_req,
    input  logic               clr_cnt,
    output logic [N_STAGE-1:0] stall,
    output logic [N_STAGE-1:0] flush,
    output logic               running,
    output logic               paused,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_enter_q;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic               w_go;
    logic               w_active;
    logic               w_any_stall;
    logic               w_flush_ok;
    logic [N_STAGE-1:0] w_stall_mask;
    logic [N_STAGE-1:0] w_below_flush;
    logic [N_STAGE-1:0] w_bubble;

    assign w_go        = enter & ~r_enter_q;
    assign w_active    = (r_state == S_RUN) | (r_state == S_STEP);
    assign w_any_stall = |stall_req;

    // Stall mask covers every stage at or below the oldest stalling stage;
    // below-flush marks every stage younger than the oldest flush request.
    always_comb begin
        logic acc_s;
        logic acc_f;
        acc_s         = 1'b0;
        acc_f         = 1'b0;
        w_stall_mask  = {N_STAGE{1'b0}};
        w_below_flush = {N_STAGE{1'b0}};
        for (int i = N_STAGE - 1; i >= 0; i--) begin
            acc_s            = acc_s | stall_req[i];
            w_stall_mask[i]  = acc_s;
            w_below_flush[i] = acc_f;
            acc_f            = acc_f | flush_req[i];
        end
    end

    // Bubble goes into the stage just above the oldest stalled one.
    always_comb begin
        w_bubble = {N_STAGE{1'b0}};
        for (int i = 1; i < N_STAGE; i++) begin
            w_bubble[i] = w_stall_mask[i-1] & ~w_stall_mask[i];
        end
    end

    // A flush applies only if some requester sits above every stalled stage.
    assign w_flush_ok = |(flush_req & ~w_stall_mask);

    // Stall/flush outputs; inactive states freeze the whole pipeline.
    always_comb begin
        stall = {N_STAGE{1'b1}};
        flush = {N_STAGE{1'b0}};
        if (w_active) begin
            if (w_flush_ok) begin
                stall = w_stall_mask & ~w_below_flush;
                flush = w_bubble | w_below_flush;
            end else begin
                stall = w_stall_mask;
                flush = w_bubble;
            end
        end else begin
            stall = {N_STAGE{1'b1}};
            flush = {N_STAGE{1'b0}};
        end
    end

    assign running      = w_active;
    assign paused       = (r_state == S_PAUSE);
    assign stall_cycles = r_stall_cycles;

    // Next-state logic; RUN checks mode_step before any button press.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = mode_step ? S_STEP : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (mode_step) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_STEP: begin
                if (!w_any_stall) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_PAUSE: begin
                if (w_go) begin
                    w_state_nxt = mode_step ? S_STEP : S_RUN;
                end else begin
                    w_state_nxt = S_PAUSE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, button history and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_enter_q      <= 1'b1;
            r_stall_cycles <= {CNT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_enter_q <= enter;
            if (clr_cnt) begin
                r_stall_cycles <= {CNT_W{1'b0}};
            end else if (w_active && w_any_stall && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

    localparam int N = 5;
    localparam int W = 4;

    typedef struct packed {
        logic [N-1:0] stall;
        logic [N-1:0] flush;
        logic         run;
        logic         pause;
        logic [W-1:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enter = 1'b0;
    logic         mode_step = 1'b0;
    logic [N-1:0] stall_req = '0;
    logic [N-1:0] flush_req = '0;
    logic         clr_cnt = 1'b0;
    logic [N-1:0] stall;
    logic [N-1:0] flush;
    logic         running;
    logic         paused;
    logic [W-1:0] stall_cycles;

    logic         chk_valid = 1'b0;
    exp_t         exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    pipeline_stall_ctrl #(.N_STAGE(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .enter(enter), .mode_step(mode_step),
        .stall_req(stall_req), .flush_req(flush_req), .clr_cnt(clr_cnt),
        .stall(stall), .flush(flush), .running(running), .paused(paused),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // One cycle: apply inputs after the edge, optionally queue the expectation.
    task automatic cyc(input logic r, input logic e, input logic m,
                       input logic [N-1:0] sr, input logic [N-1:0] fr, input logic c,
                       input logic chk, input logic [N-1:0] es, input logic [N-1:0] ef,
                       input logic er, input logic ep, input logic [W-1:0] ec,
                       input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; enter = e; mode_step = m; stall_req = sr; flush_req = fr; clr_cnt = c;
        if (chk) begin
            x.stall = es; x.flush = ef; x.run = er; x.pause = ep; x.cnt = ec;
            exp_q.push_back(x);
            name_q.push_back(nm);
        end
        chk_valid = chk;
    endtask

    // Monitor: pop one expectation per checked cycle and compare every field.
    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                exp_t x;
                string nm;
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (stall !== x.stall) begin
                    n_err++; $display("FAIL %s.stall: got %b want %b", nm, stall, x.stall);
                end
                n_cmp++;
                if (flush !== x.flush) begin
                    n_err++; $display("FAIL %s.flush: got %b want %b", nm, flush, x.flush);
                end
                n_cmp++;
                if (running !== x.run) begin
                    n_err++; $display("FAIL %s.running: got %b want %b", nm, running, x.run);
                end
                n_cmp++;
                if (paused !== x.pause) begin
                    n_err++; $display("FAIL %s.paused: got %b want %b", nm, paused, x.pause);
                end
                n_cmp++;
                if (stall_cycles !== x.cnt) begin
                    n_err++; $display("FAIL %s.stall_cycles: got %0d want %0d", nm, stall_cycles, x.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  rst  en   ms   sreq      freq      clr  chk  stall     flush     run  pau  cnt
        cyc(1'b1,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b0,4'd0,"pre");
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t1_reset");
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t1_press");
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd0,"t1_run");
        // T3: stall at stage 2
        cyc(1'b0,1'b0,1'b0,5'b00100,5'b00000,1'b0,1'b1,5'b00111,5'b01000,1'b1,1'b0,4'd0,"t3_a");
        cyc(1'b0,1'b0,1'b0,5'b00100,5'b00000,1'b0,1'b1,5'b00111,5'b01000,1'b1,1'b0,4'd1,"t3_b");
        cyc(1'b0,1'b0,1'b0,5'b00100,5'b00000,1'b0,1'b1,5'b00111,5'b01000,1'b1,1'b0,4'd2,"t3_c");
        // T4: flush alone, flush below stall, flush above stall, oldest-stage stall
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00100,1'b0,1'b1,5'b00000,5'b00011,1'b1,1'b0,4'd3,"t4_flush");
        cyc(1'b0,1'b0,1'b0,5'b01000,5'b00100,1'b0,1'b1,5'b01111,5'b10000,1'b1,1'b0,4'd3,"t4_ignored");
        cyc(1'b0,1'b0,1'b0,5'b00010,5'b10000,1'b0,1'b1,5'b00000,5'b01111,1'b1,1'b0,4'd4,"t4_override");
        cyc(1'b0,1'b0,1'b0,5'b10000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b1,1'b0,4'd5,"top_stall");
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b1,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd6,"clr_a");
        cyc(1'b0,1'b0,1'b0,5'b00001,5'b00000,1'b1,1'b1,5'b00001,5'b00010,1'b1,1'b0,4'd0,"clr_prio");
        // RUN -> PAUSE on mode_step, requests ignored while paused
        cyc(1'b0,1'b0,1'b1,5'b00000,5'b00000,1'b0,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd0,"run_to_pause");
        cyc(1'b0,1'b0,1'b1,5'b00100,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b1,4'd0,"pause_ign");
        // T5: single step with two stalled cycles
        cyc(1'b0,1'b1,1'b1,5'b00001,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b1,4'd0,"t5_press");
        cyc(1'b0,1'b1,1'b1,5'b00001,5'b00000,1'b0,1'b1,5'b00001,5'b00010,1'b1,1'b0,4'd0,"t5_step1");
        cyc(1'b0,1'b0,1'b1,5'b00001,5'b00000,1'b0,1'b1,5'b00001,5'b00010,1'b1,1'b0,4'd1,"t5_step2");
        cyc(1'b0,1'b0,1'b1,5'b00000,5'b00000,1'b0,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd2,"t5_step3");
        cyc(1'b0,1'b0,1'b1,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b1,4'd2,"t5_paused");
        // PAUSE -> RUN with free-run mode
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b1,4'd2,"resume_press");
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd2,"resume_run");
        // T6: saturation with CNT_W=4 starting from 2
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0,1'b0,1'b0,5'b11111,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b1,1'b0,
                ((2 + k) > 15) ? 4'd15 : 4'(2 + k),"t6_sat");
        end
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b1,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd15,"t6_clr");
        cyc(1'b0,1'b0,1'b0,5'b00001,5'b00000,1'b0,1'b1,5'b00001,5'b00010,1'b1,1'b0,4'd0,"t6_cleared");
        // Reset mid-run, then T2: enter held through reset
        cyc(1'b1,1'b0,1'b0,5'b00100,5'b00000,1'b0,1'b1,5'b00111,5'b01000,1'b1,1'b0,4'd1,"midrun_rst");
        cyc(1'b1,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t2_rst_held");
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t2_held_a");
        cyc(1'b0,1'b1,1'b0,5'b00100,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t2_held_b");
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t2_release");
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b11111,5'b00000,1'b0,1'b0,4'd0,"t2_press");
        cyc(1'b0,1'b1,1'b0,5'b00000,5'b00000,1'b0,1'b1,5'b00000,5'b00000,1'b1,1'b0,4'd0,"t2_run");
        cyc(1'b0,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b0,4'd0,"idle");
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
